// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with a post-reset clear sequencer and write-write collision flag.
// Optional macro DPRAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module dual_port_ram_param #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [DATA_W-1:0] d_wa,
    output logic [DATA_W-1:0] d_ra,
    output logic              vld_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] d_wb,
    output logic [DATA_W-1:0] d_rb,
    output logic              vld_b,
    output logic              busy,
    output logic              coll
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_a_q, rd_b_q;
    logic              vld_a_q, vld_b_q, coll_q;

    logic rd_en_a, rd_en_b, wr_en_a, wr_en_b, same_addr;

    // Every access is gated by READY so the clear sequence owns the array.
    assign rd_en_a   = (state == READY) && en_a && !we_a;
    assign rd_en_b   = (state == READY) && en_b && !we_b;
    assign wr_en_a   = (state == READY) && en_a && we_a;
    assign wr_en_b   = (state == READY) && en_b && we_b;
    assign same_addr = (add_a == add_b);
    assign busy      = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt     <= cnt + ADDR_W'(1);
                    vld_a_q <= 1'b0;
                    vld_b_q <= 1'b0;
                    coll_q  <= 1'b0;
                    if (&cnt) state <= READY;
                end
                READY: begin
                    // Non-blocking array reads give read-first behaviour against either port's write.
                    if (rd_en_a) rd_a_q <= mem[add_a];
                    if (rd_en_b) rd_b_q <= mem[add_b];
                    vld_a_q <= rd_en_a;
                    vld_b_q <= rd_en_b;
                    coll_q  <= wr_en_a && wr_en_b && same_addr;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // The array itself is never reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= INIT_VAL;
        end else begin
            if (wr_en_a) mem[add_a] <= d_wa;
            if (wr_en_b && !(wr_en_a && same_addr)) mem[add_b] <= d_wb;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_W-1:0] rd_a_p, rd_b_p;
    logic              vld_a_p, vld_b_p, coll_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_p  <= '0;
            rd_b_p  <= '0;
            vld_a_p <= 1'b0;
            vld_b_p <= 1'b0;
            coll_p  <= 1'b0;
        end else begin
            rd_a_p  <= rd_a_q;
            rd_b_p  <= rd_b_q;
            vld_a_p <= vld_a_q;
            vld_b_p <= vld_b_q;
            coll_p  <= coll_q;
        end
    end

    assign d_ra  = rd_a_p;
    assign d_rb  = rd_b_p;
    assign vld_a = vld_a_p;
    assign vld_b = vld_b_p;
    assign coll  = coll_p;
`else
    assign d_ra  = rd_a_q;
    assign d_rb  = rd_b_q;
    assign vld_a = vld_a_q;
    assign vld_b = vld_b_q;
    assign coll  = coll_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param (DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5).
module tb_dual_port_ram_param;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk, rst_n;
    logic       en_a, we_a, en_b, we_b;
    logic [3:0] add_a, add_b;
    logic [7:0] d_wa, d_wb, d_ra, d_rb;
    logic       vld_a, vld_b, busy, coll;

    int tests = 0;
    int fails = 0;

    dual_port_ram_param #(.ADDR_W(4), .DATA_W(8), .INIT_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .add_a(add_a), .d_wa(d_wa), .d_ra(d_ra), .vld_a(vld_a),
        .en_b(en_b), .we_b(we_b), .add_b(add_b), .d_wb(d_wb), .d_rb(d_rb), .vld_b(vld_b),
        .busy(busy), .coll(coll)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; add_a = '0; d_wa = '0;
        en_b = 1'b0; we_b = 1'b0; add_b = '0; d_wb = '0;
    endtask

    // Counts edges from release until busy drops; writes on both ports must be ignored throughout.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd0; d_wa = 8'h5A;
        en_b = 1'b1; we_b = 1'b1; add_b = 4'd0; d_wb = 8'h3C;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            tests++;
            if (busy === 1'b1 && (vld_a !== 1'b0 || vld_b !== 1'b0 || coll !== 1'b0 || d_ra !== 8'h00)) begin
                fails++;
                $display("FAIL %s_busy_outputs: edge %0d vld_a=%b vld_b=%b coll=%b d_ra=%h, want 0 0 0 00",
                         name, n, vld_a, vld_b, coll, d_ra);
            end
        end
        idle();
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL %s_clear_len: busy dropped after %0d edges, want 16", name, n);
        end
    endtask

    task automatic read_both(input logic [3:0] aa, input logic [3:0] ab,
                             output logic [7:0] ra, output logic [7:0] rb,
                             output logic va, output logic vb);
        en_a = 1'b1; we_a = 1'b0; add_a = aa;
        en_b = 1'b1; we_b = 1'b0; add_b = ab;
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        ra = d_ra; rb = d_rb; va = vld_a; vb = vld_b;
    endtask

    task automatic check_read(input string name, input logic [3:0] aa, input logic [3:0] ab,
                              input logic [7:0] ea, input logic [7:0] eb);
        logic [7:0] ra, rb;
        logic       va, vb;
        read_both(aa, ab, ra, rb, va, vb);
        tests++;
        if (ra !== ea || va !== 1'b1) begin
            fails++;
            $display("FAIL %s_a: addr %0d got d_ra=%h vld_a=%b, want %h 1", name, aa, ra, va, ea);
        end
        tests++;
        if (rb !== eb || vb !== 1'b1) begin
            fails++;
            $display("FAIL %s_b: addr %0d got d_rb=%h vld_b=%b, want %h 1", name, ab, rb, vb, eb);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if (d_ra !== 8'h00 || d_rb !== 8'h00 || vld_a !== 1'b0 || vld_b !== 1'b0 || coll !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: d_ra=%h d_rb=%h vld=%b%b coll=%b busy=%b, want 00 00 00 0 1",
                     d_ra, d_rb, vld_a, vld_b, coll, busy);
        end
    endtask

    task automatic test_clear();
        rst_n = 1'b1;
        wait_clear("clear");
        for (int i = 0; i < 16; i++) check_read("clear_read", 4'(i), 4'(15 - i), 8'hA5, 8'hA5);
    endtask

    task automatic test_basic_rw();
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd5;  d_wa = 8'h3C;
        en_b = 1'b1; we_b = 1'b1; add_b = 4'd12; d_wb = 8'hC3;
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if (vld_a !== 1'b0 || vld_b !== 1'b0 || d_ra !== 8'hA5 || d_rb !== 8'hA5 || coll !== 1'b0) begin
            fails++;
            $display("FAIL write_hold: vld=%b%b d_ra=%h d_rb=%h coll=%b, want 00 a5 a5 0",
                     vld_a, vld_b, d_ra, d_rb, coll);
        end
        check_read("basic", 4'd12, 4'd5, 8'hC3, 8'h3C);
    endtask

    task automatic test_read_first();
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd3; d_wa = 8'h77;
        en_b = 1'b1; we_b = 1'b0; add_b = 4'd3;
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if (d_rb !== 8'hA5 || vld_b !== 1'b1 || vld_a !== 1'b0) begin
            fails++;
            $display("FAIL read_first: d_rb=%h vld_b=%b vld_a=%b, want a5 1 0", d_rb, vld_b, vld_a);
        end
        check_read("after_write", 4'd3, 4'd3, 8'h77, 8'h77);
    endtask

    task automatic test_write_collision();
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd9; d_wa = 8'h11;
        en_b = 1'b1; we_b = 1'b1; add_b = 4'd9; d_wb = 8'h22;
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if (coll !== 1'b1) begin
            fails++;
            $display("FAIL coll_pulse: coll=%b, want 1", coll);
        end
        tick();
        tests++;
        if (coll !== 1'b0) begin
            fails++;
            $display("FAIL coll_width: coll=%b, want 0", coll);
        end
        check_read("coll_winner", 4'd9, 4'd9, 8'h11, 8'h11);
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd7; d_wa = 8'h44;
        en_b = 1'b1; we_b = 1'b1; add_b = 4'd8; d_wb = 8'h66;
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if (coll !== 1'b0) begin
            fails++;
            $display("FAIL coll_diff_addr: coll=%b, want 0", coll);
        end
        check_read("diff_addr", 4'd7, 4'd8, 8'h44, 8'h66);
    endtask

    task automatic test_mid_reset();
        en_a = 1'b1; we_a = 1'b1; add_a = 4'd2; d_wa = 8'h55;
        tick();
        idle();
        check_read("pre_reset", 4'd2, 4'd2, 8'h55, 8'h55);
        en_a = 1'b1; we_a = 1'b0; add_a = 4'd2;
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (d_ra !== 8'h00 || d_rb !== 8'h00 || vld_a !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: d_ra=%h d_rb=%h vld_a=%b busy=%b, want 00 00 0 1",
                     d_ra, d_rb, vld_a, busy);
        end
        idle();
        tick();
        rst_n = 1'b1;
        // Interrupt the clear partway; the counter must restart from zero.
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_clear("reclear");
        check_read("post_reset", 4'd2, 4'd12, 8'hA5, 8'hA5);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_clear();
        test_basic_rw();
        test_read_first();
        test_write_collision();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
